multicycle_control_fsm: RTL

- Main controller for the multi-cycle RV32I core.
- Sequences the shared ALU, register file, PC/IR/old_pc registers and the unified instruction/data memory through fetch, decode, execute, memory and writeback.
- Drives the 2-bit aluOp consumed by ALUControl:
  - 00 = ADD
  - 01 = SUB
  - 10 = decode from instruction
- Handshakes with a variable-latency memory and counts retired instructions.

---
 rtl/multicycle_control_fsm_pkg.sv | 78 +++++++
 rtl/multicycle_control_fsm_if.sv | 33 +++
 rtl/multicycle_control_fsm_inst_counter.sv | 14 +
 rtl/multicycle_control_fsm.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, datapath
// selector codes, aluOp codes and the RV32I major opcodes it decodes.
package multicycle_control_fsm_pkg;

  localparam logic [3:0] ST_IF       = 4'd0;
  localparam logic [3:0] ST_ID       = 4'd1;
  localparam logic [3:0] ST_EX       = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WR   = 4'd4;
  localparam logic [3:0] ST_WB       = 4'd5;
  localparam logic [3:0] ST_BR       = 4'd6;
  localparam logic [3:0] ST_BR_TAKEN = 4'd7;
  localparam logic [3:0] ST_JUMP     = 4'd8;
  localparam logic [3:0] ST_HALT     = 4'd9;

  typedef enum logic [3:0] {
    S_IF       = ST_IF,
    S_ID       = ST_ID,
    S_EX       = ST_EX,
    S_MEM_RD   = ST_MEM_RD,
    S_MEM_WR   = ST_MEM_WR,
    S_WB       = ST_WB,
    S_BR       = ST_BR,
    S_BR_TAKEN = ST_BR_TAKEN,
    S_JUMP     = ST_JUMP,
    S_HALT     = ST_HALT
  } state_e;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] M2R_ALU     = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;
  } ctrl_t;

  // Address-generation setup shared by LOAD/STORE/JALR in EX: regA + imm.
  function automatic ctrl_t ex_addr_ctrl();
    ctrl_t c;
    c = '0;
    c.alu_src_a = SRC_A_REG;
    c.alu_src_b = SRC_B_IMM;
    c.alu_op    = ALUOP_ADD;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             alu_bcond;
  logic             ecall_halt;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             is_halted;
  logic [CNT_W-1:0] num_inst;

  modport master (
    input  opcode, alu_bcond, ecall_halt, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted, num_inst
  );

  modport slave (
    output opcode, alu_bcond, ecall_halt, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted, num_inst
  );
endinterface

// File: rtl/multicycle_control_fsm_inst_counter.sv
// Retired-instruction counter: wraps naturally, cleared by async active-low reset.
module multicycle_control_fsm_inst_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller: IF/ID/EX/MEM/WB sequencing over a shared
// ALU and a unified variable-latency memory, plus retired-instruction count.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);
  state_e           state, nxt;
  ctrl_t            c, q;
  logic             cnt_en;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    c   = '0;
    case (state)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.i_or_d    = 1'b0;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALUOP_ADD;
        if (bus.mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          nxt        = S_ID;
        end
      end
      S_ID: begin
        case (bus.opcode)
          OP_ECALL:  nxt = bus.ecall_halt ? S_HALT : S_IF;
          OP_JAL:    nxt = S_JUMP;
          OP_BRANCH: nxt = S_BR;
          OP_LOAD, OP_STORE, OP_ARITH, OP_ARITH_IMM, OP_JALR: nxt = S_EX;
          default:   nxt = S_IF;  // unknown opcode retires as a nop
        endcase
      end
      S_EX: begin
        nxt = S_IF;
        case (bus.opcode)
          OP_ARITH: begin
            c.alu_src_a = SRC_A_REG;
            c.alu_src_b = SRC_B_REG;
            c.alu_op    = ALUOP_FUNCT;
            nxt         = S_WB;
          end
          OP_ARITH_IMM: begin
            c.alu_src_a = SRC_A_REG;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALUOP_FUNCT;
            nxt         = S_WB;
          end
          OP_LOAD: begin
            c   = ex_addr_ctrl();
            nxt = S_MEM_RD;
          end
          OP_STORE: begin
            c   = ex_addr_ctrl();
            nxt = S_MEM_WR;
          end
          // Link and jump in one edge: rd takes the already-incremented PC.
          OP_JALR: begin
            c            = ex_addr_ctrl();
            c.pc_write   = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_to_reg = M2R_PC;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (bus.mem_ready) nxt = S_WB;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (bus.mem_ready) nxt = S_IF;
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (bus.opcode == OP_LOAD) ? M2R_MDR : M2R_ALU;
        nxt          = S_IF;
      end
      S_BR: begin
        c.alu_src_a = SRC_A_REG;
        c.alu_src_b = SRC_B_REG;
        c.alu_op    = ALUOP_FUNCT;
        nxt         = bus.alu_bcond ? S_BR_TAKEN : S_IF;
      end
      S_BR_TAKEN: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
        nxt         = S_IF;
      end
      S_JUMP: begin
        c.alu_src_a  = SRC_A_OLDPC;
        c.alu_src_b  = SRC_B_IMM;
        c.alu_op     = ALUOP_ADD;
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_PC;
        nxt          = S_IF;
      end
      S_HALT: begin
        c.is_halted = 1'b1;
        nxt         = S_HALT;
      end
      default: nxt = S_IF;
    endcase
  end

  // Reset forces every output low at once, dropping any in-flight request.
  assign q = reset ? c : '0;

  assign bus.pc_write   = q.pc_write;
  assign bus.ir_write   = q.ir_write;
  assign bus.i_or_d     = q.i_or_d;
  assign bus.mem_read   = q.mem_read;
  assign bus.mem_write  = q.mem_write;
  assign bus.reg_write  = q.reg_write;
  assign bus.mem_to_reg = q.mem_to_reg;
  assign bus.alu_src_a  = q.alu_src_a;
  assign bus.alu_src_b  = q.alu_src_b;
  assign bus.alu_op     = q.alu_op;
  assign bus.is_halted  = q.is_halted;

  // An instruction retires whenever control returns to IF or enters HALT.
  assign cnt_en = ((nxt == S_IF)   && (state != S_IF)) ||
                  ((nxt == S_HALT) && (state != S_HALT));

  multicycle_control_fsm_inst_counter #(.CNT_W(CNT_W)) u_inst_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .count (count)
  );

  assign bus.num_inst = count;
endmodule
